wb_uart_tx: RTL and testbench
=============================

Name: wb_uart_tx

Overview:
Wishbone classic slave that buffers bytes written by a bus master and serialises them as 8N1 UART frames.
It attaches to one slave-side port of the Wishbone interconnect (o_m_*/i_m_* signals) as a consumer of master requests.
It provides a TX FIFO, a programmable baud divider and a status register for polling firmware.

Parameters:
DATA_WIDTH, 32, bus data width (only 32 supported)
ADDR_WIDTH, 32, bus address width; only i_ADDR[3:2] decoded
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
DEFAULT_DIV, 867, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks

Ports:
i_CLK  in  1  system clock
i_RST  in  1  asynchronous, active-high reset
i_ADDR  in  ADDR_WIDTH  byte address from interconnect
i_DATA  in  DATA_WIDTH  write data
o_DATA  out  DATA_WIDTH  read data, valid while o_ACK=1
i_WE  in  1  1=write, 0=read
i_SEL  in  4  byte-lane selects
i_STB  in  1  strobe
o_ACK  out  1  acknowledge
i_CYC  in  1  bus cycle active
i_TAGN  in  1  request tag
o_TAGN  out  1  tag returned with ACK
o_TX  out  1  UART serial output, idle high

Behaviour:
- Clock/reset: one clock i_CLK; i_RST is asynchronous and active-high. Reset values:
  - o_ACK=0, o_DATA=0, o_TAGN=0, o_TX=1
  - FIFO empty, BAUDDIV=DEFAULT_DIV, OVF=0, FSM=IDLE
- Request: req = i_CYC & i_STB & ~o_ACK.
  - On req, o_ACK=1 in the next cycle for exactly one cycle. Latency is 1, so back-to-back requests are acked every other cycle.
  - o_TAGN is registered as i_TAGN together with o_ACK. o_DATA is registered; it is 0 when not acking or on writes.
  - If CYC drops before ACK, nothing is latched.
- Register map (i_ADDR[3:2]):
  - 0 TXDATA: write with i_SEL[0]=1 pushes i_DATA[7:0]. If the FIFO is full, the byte is dropped and OVF is set. Reads return 0.
  - 1 STATUS (read):
    - bit0 BUSY (FSM != IDLE or FIFO not empty)
    - bit1 FULL, bit2 EMPTY, bit3 OVF
    - bits[8+:log2(FIFO_DEPTH)+1] fill count; other bits 0
    - Write with i_DATA[3]=1 and i_SEL[0]=1 clears OVF.
  - 2 BAUDDIV: read/write bits [15:0]. i_SEL[0] and i_SEL[1] gate the low and high bytes. Upper bits read 0.
  - 3: reserved; reads 0, writes ignored, still acked.
- All register side effects (push, OVF clear, BAUDDIV update) occur in the request cycle (the cycle before ACK).
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count register.
  - A simultaneous push and pop while full is allowed: count is unchanged and OVF is not set, because the pop frees the slot first.
  - A push while empty is readable by the FSM in the next cycle at the earliest.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE: o_TX=1. If the FIFO is not empty, pop the head into the shift register, latch BAUDDIV into div_q, load bit counter, go to START.
  - START: o_TX=0 for div_q+1 clocks.
  - DATA: 8 bits, LSB first, each held div_q+1 clocks.
  - STOP: o_TX=1 for div_q+1 clocks, then go to IDLE. IDLE may start the next frame on the following cycle, so there is one extra idle-high clock between frames.
  - Baud counter counts down from div_q to 0; a bit boundary occurs at 0.
  - A BAUDDIV write mid-frame affects only the next frame. BAUDDIV=0 gives 1 clock per bit.
- Reset mid-frame: o_TX returns to 1 immediately (async). The FIFO is flushed and the frame is aborted.

Test Plan:
- Reset: assert i_RST mid-operation -> o_TX=1, o_ACK=0, STATUS read = 0x00000004 (EMPTY), BAUDDIV read = 867.
- BAUDDIV=3, write 0x55 to TXDATA -> after push, START low for 4 clocks; then bits 1,0,1,0,1,0,1,0 each 4 clocks; STOP high 4 clocks; total frame 40 clocks.
- Handshake: back-to-back STB held high -> ACK pulses every other cycle; o_TAGN echoes i_TAGN of each request; write with i_SEL=4'b0000 to TXDATA -> acked, nothing pushed.
- Overflow: BAUDDIV=100, write 10 bytes rapidly (DEPTH=8) -> 1 popped into FSM, 8 buffered, 1 dropped. STATUS shows FULL=1, OVF=1, count=8; write STATUS 0x8 -> OVF=0.
- Wrap-around: stream 20 bytes 0x00..0x13 with fill kept ≤ 8 -> serial output decodes exactly 0x00..0x13 in order; STATUS EMPTY=1, BUSY=0 at the end.
- Baud change mid-frame: BAUDDIV=7, send 0xA5; write BAUDDIV=1 during DATA -> current frame keeps 8 clocks/bit, next frame 2 clocks/bit; reserved address read returns 0 and is acked.

Source files
------------

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave: TX FIFO + programmable baud divider + 8N1 serialiser.
// Latency: ACK one cycle after the request; a byte reaches o_TX two cycles after its push at the earliest.
// Backpressure: none on the bus (always acks); a push into a full FIFO is dropped and flagged in OVF.

// Generic circular FIFO with a registered fill count.
// Latency: a push is visible on rd_vld/rd_dat the cycle after it is written.
// Backpressure: wr_rdy drops when full unless a pop in the same cycle frees the slot.
module wb_uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          wr_rdy,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] fill,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = rd_rdy & ~empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign wr_rdy  = ~full | do_pop;
    assign do_push = wr_vld & wr_rdy;
    assign rd_vld  = ~empty;
    assign rd_dat  = mem[rd_ptr];
    assign fill    = cnt;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// Top level: register decode, bus response, TX FIFO and the 8N1 frame FSM.
// Latency: o_ACK/o_DATA/o_TAGN registered, one cycle after the request.
// Backpressure: back-to-back strobes are acked every other cycle; FIFO overflow drops data and sets OVF.
module wb_uart_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 867
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    output logic                  o_ACK,
    input  logic                  i_CYC,
    input  logic                  i_TAGN,
    output logic                  o_TAGN,
    output logic                  o_TX
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Bus decode
    logic                  req;
    logic                  wr_req;
    logic [1:0]            reg_sel;
    logic                  push_vld;
    logic                  ovf_set;
    logic                  ovf_clr;
    logic                  div_wr;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] status_dat;

    // Registers
    logic                  ovf;
    logic [15:0]           bauddiv;

    // FIFO interface
    logic                  fifo_wr_rdy;
    logic                  fifo_rd_vld;
    logic [7:0]            fifo_rd_dat;
    logic [CW-1:0]         fifo_fill;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    // Transmitter state
    tx_state_t             state;
    logic [7:0]            shift_q;
    logic [15:0]           div_q;
    logic [15:0]           baud_cnt;
    logic [2:0]            bit_cnt;
    logic                  tx_q;
    logic                  busy;

    // Address bits outside [3:2], upper data bits and upper lanes have no function here.
    logic                  unused_inputs;
    assign unused_inputs = ^{i_ADDR[ADDR_WIDTH-1:4], i_ADDR[1:0],
                             i_DATA[DATA_WIDTH-1:16], i_SEL[3:2]};

    assign req      = i_CYC & i_STB & ~o_ACK;
    assign wr_req   = req & i_WE;
    assign reg_sel  = i_ADDR[3:2];
    assign push_vld = wr_req & (reg_sel == REG_TXDATA) & i_SEL[0];
    assign ovf_set  = push_vld & ~fifo_wr_rdy;
    assign ovf_clr  = wr_req & (reg_sel == REG_STATUS) & i_SEL[0] & i_DATA[3];
    assign div_wr   = wr_req & (reg_sel == REG_BAUD);
    assign pop      = (state == ST_IDLE) & fifo_rd_vld;
    assign busy     = (state != ST_IDLE) | ~fifo_empty;
    assign o_TX     = tx_q;

    wb_uart_tx_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_CLK),
        .rst    (i_RST),
        .wr_vld (push_vld),
        .wr_dat (i_DATA[7:0]),
        .wr_rdy (fifo_wr_rdy),
        .rd_rdy (pop),
        .rd_vld (fifo_rd_vld),
        .rd_dat (fifo_rd_dat),
        .fill   (fifo_fill),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Assemble the STATUS word from live flags and the FIFO fill count.
    always_comb begin
        status_dat          = '0;
        status_dat[0]       = busy;
        status_dat[1]       = fifo_full;
        status_dat[2]       = fifo_empty;
        status_dat[3]       = ovf;
        status_dat[8 +: CW] = fifo_fill;
    end

    // Read mux; TXDATA and the reserved slot read as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: rd_mux = status_dat;
            REG_BAUD:   rd_mux[15:0] = bauddiv;
            default:    rd_mux = '0;
        endcase
    end

    // Registered bus response: one-cycle ACK pulse with tag and read data.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_ACK  <= 1'b0;
            o_TAGN <= 1'b0;
            o_DATA <= '0;
        end else begin
            o_ACK  <= req;
            o_TAGN <= req ? i_TAGN : 1'b0;
            o_DATA <= (req & ~i_WE) ? rd_mux : '0;
        end
    end

    // Control registers; side effects land in the request cycle.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ovf     <= 1'b0;
            bauddiv <= 16'(DEFAULT_DIV);
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (div_wr && i_SEL[0]) begin
                bauddiv[7:0] <= i_DATA[7:0];
            end
            if (div_wr && i_SEL[1]) begin
                bauddiv[15:8] <= i_DATA[15:8];
            end
        end
    end

    // Frame FSM: divider is latched at frame start so mid-frame BAUDDIV writes wait for the next frame.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state    <= ST_IDLE;
            tx_q     <= 1'b1;
            shift_q  <= '0;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_rd_vld) begin
                        shift_q  <= fifo_rd_dat;
                        div_q    <= bauddiv;
                        baud_cnt <= bauddiv;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        tx_q     <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                        baud_cnt <= div_q;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= div_q;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: bus transfers, register map, frame decoding.
// Latency: checks one-cycle ACK on every transfer and exact bit periods on every frame.
// Backpressure: polls STATUS.FULL before streaming; overflow case writes blindly.
module tb_wb_uart_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        tag_in = 1'b0;
    logic        ack;
    logic        tag_out;
    logic        tx;

    always #5 clk = ~clk;

    wb_uart_tx #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (867)
    ) dut (
        .i_CLK  (clk),
        .i_RST  (rst),
        .i_ADDR (adr),
        .i_DATA (wdat),
        .o_DATA (rdat),
        .i_WE   (we),
        .i_SEL  (sel),
        .i_STB  (stb),
        .o_ACK  (ack),
        .i_CYC  (cyc),
        .i_TAGN (tag_in),
        .o_TAGN (tag_out),
        .o_TX   (tx)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state: bytes expected on the line and their bit period.
    int          cur_div = 867;
    logic [7:0]  exp_q[$];
    int          per_q[$];
    logic [7:0]  got_q[$];
    bit          mon_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One Wishbone transfer; checks ACK latency, tag echo and zero data on writes.
    task automatic wb_xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        logic t;
        int   n;
        t = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        adr    = ($urandom() & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
        wdat   = d;
        we     = w;
        sel    = s;
        tag_in = t;
        cyc    = 1'b1;
        stb    = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 4);
        chk("ack_latency", n, 1);
        chk("tag_echo", {31'd0, tag_out}, {31'd0, t});
        q = rdat;
        if (w) chk("wr_data_zero", rdat, 32'd0);
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        sel = '0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_xfer(1'b1, r, d, s, q);
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] q);
        wb_xfer(1'b0, r, $urandom(), 4'b1111, q);
    endtask

    task automatic set_div(input int d);
        wr(2'd2, d, 4'b0011);
        cur_div = d;
    endtask

    // Wait for room, push one byte and record what the line should carry.
    task automatic push_byte(input logic [7:0] b);
        logic [31:0] st;
        int n;
        n = 0;
        rd(2'd1, st);
        while (st[1] && n < 5000) begin
            rd(2'd1, st);
            n++;
        end
        wr(2'd0, {24'd0, b}, 4'b0001);
        exp_q.push_back(b);
        per_q.push_back(cur_div + 1);
    endtask

    // Wait (bounded) for all expected frames, then compare in order.
    task automatic drain_and_compare(input int budget);
        int c;
        int n;
        logic [7:0] e;
        logic [31:0] g;
        c = 0;
        n = exp_q.size();
        while (got_q.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rx_count", got_q.size(), n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? {24'd0, got_q.pop_front()} : 32'hDEAD;
            chk("rx_byte", g, {24'd0, e});
        end
    endtask

    // Line monitor: samples o_TX once per clock and decodes a frame with the expected period.
    initial begin : line_monitor
        int         p;
        int         glitch;
        bit         abort;
        logic [9:0] bits;
        forever begin
            @(posedge clk); #1;
            if (mon_en && !rst && tx === 1'b0) begin
                chk("frame_expected", {31'd0, per_q.size() > 0}, 32'd1);
                p      = (per_q.size() > 0) ? per_q.pop_front() : 1;
                glitch = 0;
                abort  = 1'b0;
                bits   = '0;
                for (int c = 0; c < 10 * p; c++) begin
                    if (c > 0) begin
                        @(posedge clk); #1;
                    end
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    if (c % p == 0) bits[c / p] = tx;
                    else if (tx !== bits[c / p]) glitch++;
                end
                if (!abort) begin
                    chk("stop_bit", {31'd0, bits[9]}, 32'd1);
                    chk("bit_stable", glitch, 0);
                    got_q.push_back(bits[8:1]);
                    @(posedge clk); #1;
                    chk("idle_gap", {31'd0, tx}, 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] q;
        logic        prev_tag;
        int          acks;
        int          n;
        int          nb;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_data", rdat, 32'd0);
        chk("rst_tag", {31'd0, tag_out}, 32'd0);
        rst = 1'b0;

        // Register reset state and zero-reading slots
        rd(2'd1, q); chk("status_reset", q, 32'h0000_0004);
        rd(2'd2, q); chk("baud_reset", q, 32'd867);
        rd(2'd0, q); chk("txdata_reads_zero", q, 32'd0);
        rd(2'd3, q); chk("reserved_reads_zero", q, 32'd0);

        // STB without CYC: no ACK, nothing pushed
        @(posedge clk); #1;
        adr = 32'h0; wdat = 32'h77; we = 1'b1; sel = 4'b0001; stb = 1'b1; cyc = 1'b0;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 1'b0; we = 1'b0; sel = '0;
        chk("no_ack_without_cyc", acks, 0);

        // Held strobe: ACK every other cycle, tag of each request returned; SEL=0 pushes nothing
        @(posedge clk); #1;
        adr = 32'h0; wdat = $urandom(); we = 1'b1; sel = 4'b0000; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tag_in = 1'($urandom_range(0, 1));
            prev_tag = tag_in;
            @(posedge clk); #1;
            chk("hs_ack", {31'd0, ack}, k % 2);
            if (k % 2 == 1) chk("hs_tag", {31'd0, tag_out}, {31'd0, prev_tag});
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rd(2'd1, q); chk("status_after_sel0", q, 32'h0000_0004);

        // BAUDDIV byte-lane gating and upper bits
        wr(2'd2, 32'h0000_ABCD, 4'b0001);
        rd(2'd2, q); chk("baud_low_lane", q, 32'h0000_03CD);
        wr(2'd2, 32'h0000_1200, 4'b0010);
        rd(2'd2, q); chk("baud_high_lane", q, 32'h0000_12CD);
        wr(2'd2, 32'hFFFF_1234, 4'b1111);
        rd(2'd2, q); chk("baud_upper_zero", q, 32'h0000_1234);

        // Single frame, 4 clocks per bit
        set_div(3);
        push_byte(8'h55);
        drain_and_compare(200);

        // Overflow: one byte to the FSM, eight buffered, one dropped
        set_div(100);
        for (int i = 0; i < 10; i++) begin
            wr(2'd0, 32'hA0 + i, 4'b0001);
            if (i < 9) begin
                exp_q.push_back(8'(8'hA0 + i));
                per_q.push_back(cur_div + 1);
            end
        end
        rd(2'd1, q); chk("status_overflow", q, 32'h0000_080B);
        wr(2'd1, 32'h0000_0008, 4'b0001);
        rd(2'd1, q); chk("status_ovf_cleared", q, 32'h0000_0803);
        drain_and_compare(12000);

        // Stream with wrap-around of the FIFO pointers
        set_div(2);
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        drain_and_compare(2000);
        rd(2'd1, q); chk("status_idle_after_stream", q, 32'h0000_0004);

        // Randomized batches with random divider (including 1 clock per bit) and gaps
        for (int r = 0; r < 4; r++) begin
            set_div((r == 0) ? 0 : $urandom_range(0, 4));
            nb = $urandom_range(3, 12);
            for (int i = 0; i < nb; i++) begin
                push_byte(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 20)) @(posedge clk);
            end
            drain_and_compare(3000);
            rd(2'd1, q); chk("status_idle_random", q, 32'h0000_0004);
        end

        // Divider change mid-frame only affects the following frame
        set_div(7);
        push_byte(8'hA5);
        repeat (24) @(posedge clk);
        set_div(1);
        push_byte(8'h3C);
        rd(2'd3, q); chk("reserved_midframe", q, 32'd0);
        rd(2'd2, q); chk("baud_readback", q, 32'd1);
        drain_and_compare(400);

        // Reset mid-frame: line idles at once, FIFO flushed, registers back to defaults
        mon_en = 1'b0;
        set_div(20);
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h0F, 4'b0001);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_frame_started", {31'd0, tx}, 32'd0);
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, tx}, 32'd1);
        chk("rst_async_ack", {31'd0, ack}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rd(2'd1, q); chk("status_after_rst", q, 32'h0000_0004);
        rd(2'd2, q); chk("baud_after_rst", q, 32'd867);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) n++;
        end
        chk("tx_idle_after_rst", n, 0);
        chk("stray_frames", got_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
